// File: rtl/digit_entry_pkg.sv
// digit_entry_pkg: shared types and constants for the front-panel digit editor
package digit_entry_pkg;
  typedef enum logic [1:0] {CLEAR, EDIT, LOCKED} entry_state_t;
  typedef logic [3:0] digit_t;
  localparam int NUM_DIGITS = 4;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_ENTER  = 4;
  localparam int NUM_BTNS   = 5;
endpackage

// File: rtl/digit_entry_ctrl_btn_debouncer.sv
// btn_debouncer: 2-FF synchroniser, debounce counter and press pulse for one button
// Ports: clk, rst_n (async active-low), btn_i raw level,
//        stable_o debounced level, press_o one-cycle pulse on debounced rising edge.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d, press_q, press_d, mism, flip;
  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
  always_comb begin
    mism     = sync_q[1] != stable_q;
    flip     = mism && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d    = (!mism || flip) ? '0 : cnt_q + 1'b1;
    stable_d = flip ? ~stable_q : stable_q;
    press_d  = flip && !stable_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end
  assign stable_o = stable_q;
  assign press_o  = press_q;
endmodule

// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: debounced four-digit BCD editor driving the 7-seg digit-write port
// Ports: clk, rst_n (async active-low); btn_up/down/left/right/enter raw buttons;
//        game_started freezes editing, game_finished enables unlock;
//        en_write/dig_loc/dig_value one-cycle display write; cursor, digits {d3..d0};
//        entry_done commit pulse; locked high in LOCKED.
// Optional: define DIGIT_ENTRY_AUTOREPEAT_EN for up/down auto-repeat every REPEAT_CYCLES.
module digit_entry_ctrl
  import digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_VALUE       = 9,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_enter,
  input  logic        game_started,
  input  logic        game_finished,
  output logic        en_write,
  output logic [1:0]  dig_loc,
  output logic [3:0]  dig_value,
  output logic [1:0]  cursor,
  output logic [15:0] digits,
  output logic        entry_done,
  output logic        locked
);
  localparam digit_t MAXV = digit_t'(MAX_VALUE);
  logic [NUM_BTNS-1:0] raw, stable, press, act;
  entry_state_t state_q, state_d;
  logic [1:0] clr_idx_q, clr_idx_d, cursor_q, cursor_d, dig_loc_q, dig_loc_d;
  digit_t [NUM_DIGITS-1:0] digits_q, digits_d;
  digit_t dig_value_q, dig_value_d, cur, new_val;
  logic en_write_q, en_write_d, entry_done_q, entry_done_d;
  logic edit_ok, do_enter, do_up, do_dn, do_left, do_right;
  logic unused_sig;
  assign raw = {btn_enter, btn_right, btn_left, btn_down, btn_up};
  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst_n(rst_n), .btn_i(raw[g]), .stable_o(stable[g]), .press_o(press[g])
    );
  end
`ifdef DIGIT_ENTRY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic rep_held, rep_hit;
  // Counter runs only while up/down is held in EDIT, so leaving EDIT or releasing clears it.
  always_comb begin
    rep_held  = state_q == EDIT && (stable[BTN_UP] || stable[BTN_DOWN]);
    rep_hit   = rep_held && rep_cnt_q == RW'(REPEAT_CYCLES - 1);
    rep_cnt_d = (!rep_held || rep_hit) ? '0 : rep_cnt_q + 1'b1;
    act       = press;
    act[BTN_UP]   = press[BTN_UP] | (rep_hit & stable[BTN_UP]);
    act[BTN_DOWN] = press[BTN_DOWN] | (rep_hit & stable[BTN_DOWN] & ~stable[BTN_UP]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt_q <= '0;
    else rep_cnt_q <= rep_cnt_d;
  end
  assign unused_sig = ^stable[NUM_BTNS-1:BTN_LEFT];
`else
  assign act = press;
  assign unused_sig = ^{REPEAT_CYCLES, stable};
`endif
  // Priority decode: enter > up > down > left > right; lower presses in the same cycle drop.
  always_comb begin
    edit_ok  = state_q == EDIT && !game_started;
    do_enter = act[BTN_ENTER];
    do_up    = act[BTN_UP] && !do_enter;
    do_dn    = act[BTN_DOWN] && !do_enter && !act[BTN_UP];
    do_left  = act[BTN_LEFT] && !do_enter && !act[BTN_UP] && !act[BTN_DOWN];
    do_right = act[BTN_RIGHT] && !do_enter && !act[BTN_UP] && !act[BTN_DOWN] && !act[BTN_LEFT];
    cur      = digits_q[cursor_q];
    new_val  = do_up ? (cur >= MAXV ? '0 : cur + 1'b1) : (cur == '0 ? MAXV : cur - 1'b1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      cursor_q     <= '0;
      digits_q     <= '0;
      en_write_q   <= 1'b0;
      dig_loc_q    <= '0;
      dig_value_q  <= '0;
      entry_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      cursor_q     <= cursor_d;
      digits_q     <= digits_d;
      en_write_q   <= en_write_d;
      dig_loc_q    <= dig_loc_d;
      dig_value_q  <= dig_value_d;
      entry_done_q <= entry_done_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cursor_d  = cursor_q;
    digits_d  = digits_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == 2'd3) begin
          state_d  = EDIT;
          digits_d = '0;
          cursor_d = '0;
        end
      end
      EDIT: if (edit_ok) begin
        if (do_enter) state_d = LOCKED;
        if (do_up || do_dn) digits_d[cursor_q] = new_val;
        if (do_left) cursor_d = cursor_q + 1'b1;
        if (do_right) cursor_d = cursor_q - 1'b1;
      end
      LOCKED: if (act[BTN_ENTER] && game_finished) begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
      default: state_d = CLEAR;
    endcase
  end
  // CLEAR writes and edit writes cannot coincide since they belong to different states.
  always_comb begin
    en_write_d   = state_q == CLEAR || (edit_ok && (do_up || do_dn));
    dig_loc_d    = !en_write_d ? dig_loc_q : state_q == CLEAR ? clr_idx_q : cursor_q;
    dig_value_d  = !en_write_d ? dig_value_q : state_q == CLEAR ? '0 : new_val;
    entry_done_d = edit_ok && do_enter;
  end
  assign en_write   = en_write_q;
  assign dig_loc    = dig_loc_q;
  assign dig_value  = dig_value_q;
  assign cursor     = cursor_q;
  assign digits     = digits_q;
  assign entry_done = entry_done_q;
  assign locked     = state_q == LOCKED;
endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb_digit_entry_ctrl: scoreboard bench for digit_entry_ctrl with short debounce/repeat times
module tb_digit_entry_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, gs = 1'b0, gf = 1'b0;
  logic [4:0] btn = '0;
  logic en_write, entry_done, locked;
  logic [1:0] dig_loc, cursor;
  logic [3:0] dig_value;
  logic [15:0] digits;
  logic [5:0] exp_q[$];
  int vecs = 0, errs = 0, done_cnt = 0;

  digit_entry_ctrl #(.DEBOUNCE_CYCLES(4), .MAX_VALUE(9), .REPEAT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_enter(btn[4]),
    .game_started(gs), .game_finished(gf),
    .en_write(en_write), .dig_loc(dig_loc), .dig_value(dig_value),
    .cursor(cursor), .digits(digits), .entry_done(entry_done), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en_write) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write: got loc=%0d val=%0d, required no write", dig_loc, dig_value);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({dig_loc, dig_value} !== e) begin
          errs++;
          $display("FAIL write: got loc=%0d val=%0d, required loc=%0d val=%0d",
                   dig_loc, dig_value, e[5:4], e[3:0]);
        end
      end
    end
    if (entry_done) done_cnt++;
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(logic [4:0] m);
    btn = m;
    tick(10);
    btn = '0;
    tick(10);
  endtask

  task automatic push(logic [1:0] loc, logic [3:0] val);
    exp_q.push_back({loc, val});
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin
    int v;
    tick(3);
    check("rst_en_write", 32'(en_write), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_digits", 32'(digits), 0);
    check("rst_cursor", 32'(cursor), 0);
    check("rst_entry_done", 32'(entry_done), 0);
    for (int i = 0; i < 4; i++) push(2'(i), 4'd0);
    rst_n = 1'b1;
    tick(10);
    check("clear_writes_seen", 32'(exp_q.size()), 0);
    check("clear_digits", 32'(digits), 0);
    check("clear_locked", 32'(locked), 0);
    push(2'd0, 4'd1);
    press(5'b00001);
    btn = 5'b00001;
    tick(2);
    btn = '0;
    tick(10);
    check("glitch_digits", 32'(digits), 32'h0001);
    v = 1;
    for (int i = 0; i < 9; i++) begin
      v = (v == 9) ? 0 : v + 1;
      push(2'd0, 4'(v));
      press(5'b00001);
    end
    check("wrap_up_digits", 32'(digits), 32'h0000);
    push(2'd0, 4'd9);
    press(5'b00010);
    check("wrap_down_digits", 32'(digits), 32'h0009);
    push(2'd0, 4'd0);
    press(5'b00001);
    repeat (3) press(5'b00100);
    check("cursor_left3", 32'(cursor), 3);
    push(2'd3, 4'd1);
    press(5'b00001);
    push(2'd3, 4'd2);
    press(5'b00001);
    check("digits_2000", 32'(digits), 32'h2000);
    press(5'b01000);
    check("cursor_right", 32'(cursor), 2);
    press(5'b00100);
    press(5'b00100);
    check("cursor_wrap", 32'(cursor), 0);
    push(2'd0, 4'd1);
    press(5'b00011);
    push(2'd0, 4'd2);
    press(5'b00101);
    check("prio_cursor", 32'(cursor), 0);
    check("prio_digits", 32'(digits), 32'h2002);
    press(5'b10001);
    check("enter_locked", 32'(locked), 1);
    check("enter_pulse", 32'(done_cnt), 1);
    check("enter_digits", 32'(digits), 32'h2002);
    press(5'b00001);
    press(5'b10000);
    check("locked_hold", 32'(locked), 1);
    gf = 1'b1;
    for (int i = 0; i < 4; i++) push(2'(i), 4'd0);
    press(5'b10000);
    gf = 1'b0;
    check("unlock_locked", 32'(locked), 0);
    check("unlock_digits", 32'(digits), 0);
    check("unlock_cursor", 32'(cursor), 0);
    check("unlock_no_pulse", 32'(done_cnt), 1);
    gs = 1'b1;
    press(5'b00001);
    press(5'b10000);
    check("frozen_digits", 32'(digits), 0);
    check("frozen_locked", 32'(locked), 0);
    gs = 1'b0;
    push(2'd0, 4'd1);
    press(5'b00001);
`ifdef DIGIT_ENTRY_AUTOREPEAT_EN
    push(2'd0, 4'd2);
    push(2'd0, 4'd3);
    push(2'd0, 4'd4);
    btn = 5'b00001;
    tick(40);
    btn = '0;
    tick(10);
    check("repeat_digits", 32'(digits), 32'h0004);
`endif
    tick(5);
    check("all_writes_seen", 32'(exp_q.size()), 0);
    check("final_digits", 32'(digits), 32'(exp_q.size() == 0 ? digits : 16'hFFFF));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
